// File: rtl/operand_fwd_reg.sv
// ID-stage operand selector with EX/MEM/WB forwarding, XZR handling and
// load-use detection, feeding the registered ID/EX operand slot.
module operand_fwd_reg #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_REG  = 31
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [NUM_PORTS-1:0]        rd_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] rf_data_i,
  input  logic                        ex_we_i,
  input  logic                        ex_is_load_i,
  input  logic [ADDR_W-1:0]           ex_waddr_i,
  input  logic [DATA_W-1:0]           ex_wdata_i,
  input  logic                        mem_we_i,
  input  logic [ADDR_W-1:0]           mem_waddr_i,
  input  logic [DATA_W-1:0]           mem_wdata_i,
  input  logic                        wb_we_i,
  input  logic [ADDR_W-1:0]           wb_waddr_i,
  input  logic [DATA_W-1:0]           wb_wdata_i,
  output logic [NUM_PORTS*DATA_W-1:0] operand_o,
  output logic [NUM_PORTS*2-1:0]      fwd_sel_o,
  output logic                        valid_o,
  output logic                        load_use_stall_o
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  // A producer targeting XZR never forwards; an EX load has no data yet.
  logic ex_fwd, ex_ld, mem_fwd, wb_fwd;
  assign ex_fwd  = ex_we_i & ~ex_is_load_i & (ex_waddr_i != ZR);
  assign ex_ld   = ex_we_i &  ex_is_load_i & (ex_waddr_i != ZR);
  assign mem_fwd = mem_we_i & (mem_waddr_i != ZR);
  assign wb_fwd  = wb_we_i  & (wb_waddr_i  != ZR);

  logic [NUM_PORTS*DATA_W-1:0] sel_data;
  logic [NUM_PORTS*2-1:0]      sel_src;
  logic [NUM_PORTS-1:0]        hz;
  logic                        load_use;

  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    hz       = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_en_i[p] && (rd_addr_i[p*ADDR_W +: ADDR_W] != ZR)) begin
        if (ex_fwd && (ex_waddr_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
          sel_data[p*DATA_W +: DATA_W] = ex_wdata_i;
          sel_src[p*2 +: 2]            = 2'd1;
        end else if (mem_fwd && (mem_waddr_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
          sel_data[p*DATA_W +: DATA_W] = mem_wdata_i;
          sel_src[p*2 +: 2]            = 2'd2;
        end else if (wb_fwd && (wb_waddr_i == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
          sel_data[p*DATA_W +: DATA_W] = wb_wdata_i;
          sel_src[p*2 +: 2]            = 2'd3;
        end else begin
          sel_data[p*DATA_W +: DATA_W] = rf_data_i[p*DATA_W +: DATA_W];
          sel_src[p*2 +: 2]            = 2'd0;
        end
        // The EX load is the youngest producer, so older matches cannot hide it.
        hz[p] = ex_ld && (ex_waddr_i == rd_addr_i[p*ADDR_W +: ADDR_W]);
      end
    end
  end

  assign load_use         = |hz;
  assign load_use_stall_o = load_use & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      operand_o <= '0;
      fwd_sel_o <= '0;
      valid_o   <= 1'b0;
    end else if (flush_i) begin
      operand_o <= '0;
      fwd_sel_o <= '0;
      valid_o   <= 1'b0;
    end else if (stall_i) begin
      operand_o <= operand_o;
      fwd_sel_o <= fwd_sel_o;
      valid_o   <= valid_o;
    end else if (load_use) begin
      operand_o <= '0;
      fwd_sel_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      operand_o <= sel_data;
      fwd_sel_o <= sel_src;
      valid_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_fwd_reg.sv
// Bench for operand_fwd_reg: vector table on the default 2-port/64-bit build,
// hand sequences for reset, plus a 3-port/32-bit build rerunning the basic cases.
module tb_operand_fwd_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [127:0] rf_data;
  logic        ex_we, ex_ld, mem_we, wb_we;
  logic [4:0]  ex_a, mem_a, wb_a;
  logic [63:0] ex_d, mem_d, wb_d;
  logic [127:0] operand;
  logic [3:0]  fwd_sel;
  logic        valid, lus;

  // Second build: 3 ports, 32-bit data, sharing control/address lines.
  logic [2:0]  rd_en3;
  logic [14:0] rd_addr3;
  logic [95:0] rf3;
  logic [31:0] ex_d3, mem_d3, wb_d3;
  logic [95:0] operand3;
  logic [5:0]  fwd_sel3;
  logic        valid3, lus3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  operand_fwd_reg u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_data_i(rf_data),
    .ex_we_i(ex_we), .ex_is_load_i(ex_ld), .ex_waddr_i(ex_a), .ex_wdata_i(ex_d),
    .mem_we_i(mem_we), .mem_waddr_i(mem_a), .mem_wdata_i(mem_d),
    .wb_we_i(wb_we), .wb_waddr_i(wb_a), .wb_wdata_i(wb_d),
    .operand_o(operand), .fwd_sel_o(fwd_sel), .valid_o(valid), .load_use_stall_o(lus)
  );

  operand_fwd_reg #(.DATA_W(32), .NUM_PORTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .rd_en_i(rd_en3), .rd_addr_i(rd_addr3), .rf_data_i(rf3),
    .ex_we_i(ex_we), .ex_is_load_i(ex_ld), .ex_waddr_i(ex_a), .ex_wdata_i(ex_d3),
    .mem_we_i(mem_we), .mem_waddr_i(mem_a), .mem_wdata_i(mem_d3),
    .wb_we_i(wb_we), .wb_waddr_i(wb_a), .wb_wdata_i(wb_d3),
    .operand_o(operand3), .fwd_sel_o(fwd_sel3), .valid_o(valid3), .load_use_stall_o(lus3)
  );

  typedef struct {
    logic        stall, flush;
    logic [1:0]  rd_en;
    logic [4:0]  a0, a1;
    logic [63:0] rf0, rf1;
    logic        ex_we, ex_ld, mem_we, wb_we;
    logic [4:0]  ex_a, mem_a, wb_a;
    logic [63:0] ex_d, mem_d, wb_d;
    logic        e_lus, e_valid, e_chk_sel;
    logic [63:0] e_op0, e_op1;
    logic [1:0]  e_s0, e_s1;
  } vec_t;

  localparam int EW = 134;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t new_vec();
    vec_t v;
    v = '{default: '0};
    v.rd_en = 2'b11;
    v.e_valid = 1'b1;
    v.e_chk_sel = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stall = v.stall;  flush = v.flush;
    rd_en = v.rd_en;  rd_addr = {v.a1, v.a0};  rf_data = {v.rf1, v.rf0};
    ex_we = v.ex_we;  ex_ld = v.ex_ld;  ex_a = v.ex_a;  ex_d = v.ex_d;
    mem_we = v.mem_we; mem_a = v.mem_a; mem_d = v.mem_d;
    wb_we = v.wb_we;  wb_a = v.wb_a;  wb_d = v.wb_d;
  endtask

  task automatic idle();
    drive(new_vec());
    rd_en = '0; rd_en3 = '0; rd_addr3 = '0; rf3 = '0;
    ex_d3 = '0; mem_d3 = '0; wb_d3 = '0;
  endtask

  initial begin
    logic [EW-1:0] e;
    vec_t v;

    // 1: RF path
    v = new_vec(); v.a0 = 3; v.rf0 = 64'h11; v.a1 = 4; v.rf1 = 64'h22;
    v.e_op0 = 64'h11; v.e_op1 = 64'h22; vecs[0] = v;
    // 2: EX beats MEM beats WB
    v = new_vec(); v.a0 = 5; v.a1 = 4; v.rf0 = 64'h99; v.rf1 = 64'h22;
    v.ex_we = 1; v.ex_a = 5; v.ex_d = 64'hA; v.mem_we = 1; v.mem_a = 5; v.mem_d = 64'hB;
    v.wb_we = 1; v.wb_a = 5; v.wb_d = 64'hC;
    v.e_op0 = 64'hA; v.e_s0 = 1; v.e_op1 = 64'h22; vecs[1] = v;
    // MEM wins without EX; both ports on the same address agree
    v.ex_we = 0; v.a1 = 5; v.e_op0 = 64'hB; v.e_s0 = 2; v.e_op1 = 64'hB; v.e_s1 = 2; vecs[2] = v;
    // WB only; port1 disabled reads zero
    v = new_vec(); v.a0 = 5; v.rf0 = 64'h77; v.wb_we = 1; v.wb_a = 5; v.wb_d = 64'hC;
    v.rd_en = 2'b01; v.a1 = 9; v.rf1 = 64'h44; v.e_op0 = 64'hC; v.e_s0 = 3; vecs[3] = v;
    // 3: XZR reads zero even when EX targets it
    v = new_vec(); v.a0 = 31; v.rf0 = 64'h99; v.ex_we = 1; v.ex_a = 31; v.ex_d = 64'hFF;
    v.a1 = 6; v.rf1 = 64'h66; v.e_op1 = 64'h66; vecs[4] = v;
    // 4: load-use on port1, MEM match on same address must not mask it
    v = new_vec(); v.a0 = 3; v.rf0 = 64'h11; v.a1 = 7; v.rf1 = 64'h10;
    v.ex_we = 1; v.ex_ld = 1; v.ex_a = 7; v.ex_d = 64'hDEAD; v.mem_we = 1; v.mem_a = 7; v.mem_d = 64'h33;
    v.e_lus = 1; v.e_valid = 0; v.e_chk_sel = 0; vecs[5] = v;
    // re-present: load now in MEM
    v = new_vec(); v.a0 = 3; v.rf0 = 64'h11; v.a1 = 7; v.rf1 = 64'h10;
    v.mem_we = 1; v.mem_a = 7; v.mem_d = 64'h55;
    v.e_op0 = 64'h11; v.e_op1 = 64'h55; v.e_s1 = 2; vecs[6] = v;
    // 5: stall holds for 3 cycles with changing inputs (one carries a hazard)
    v = new_vec(); v.stall = 1; v.a0 = 5; v.ex_we = 1; v.ex_a = 5; v.ex_d = 64'hAB;
    v.e_op0 = 64'h11; v.e_op1 = 64'h55; v.e_s1 = 2; vecs[7] = v;
    v.ex_ld = 1; v.ex_a = 3; v.a0 = 3; v.e_lus = 1; vecs[8] = v;
    v.ex_ld = 0; v.ex_a = 9; v.a1 = 9; v.rf1 = 64'h1234; v.e_lus = 0; vecs[9] = v;
    // flush with stall: flush wins
    v.flush = 1; v.e_valid = 0; v.e_op0 = 0; v.e_op1 = 0; v.e_s1 = 0; vecs[10] = v;
    // normal after flush; port1 reads XZR
    v = new_vec(); v.a0 = 8; v.rf0 = 64'h1234; v.a1 = 31; v.rf1 = 64'h5;
    v.e_op0 = 64'h1234; vecs[11] = v;
    // disabled port never raises a hazard
    v = new_vec(); v.rd_en = 2'b10; v.a0 = 7; v.rf0 = 64'h3; v.a1 = 2; v.rf1 = 64'h2;
    v.ex_we = 1; v.ex_ld = 1; v.ex_a = 7; v.e_op1 = 64'h2; vecs[12] = v;
    // load to XZR is not a hazard
    v = new_vec(); v.a0 = 31; v.a1 = 4; v.rf1 = 64'h4; v.ex_we = 1; v.ex_ld = 1; v.ex_a = 31;
    v.e_op1 = 64'h4; vecs[13] = v;

    // Reset with a hazard on the inputs: stall output forced low
    idle();
    rst = 1'b1; rd_en = 2'b01; rd_addr = 10'd7; ex_we = 1; ex_ld = 1; ex_a = 7;
    #1 check("rst_lus", {63'd0, lus}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_op0", operand[63:0], 64'd0);
    check("rst_op1", operand[127:64], 64'd0);
    check("rst_sel", {60'd0, fwd_sel}, 64'd0);
    @(negedge clk); rst = 1'b0; idle();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("v%0d_lus", i), {63'd0, lus}, {63'd0, vecs[i].e_lus});
      exp_q.push_back({vecs[i].e_chk_sel, vecs[i].e_valid, vecs[i].e_op1, vecs[i].e_op0,
                       vecs[i].e_s1, vecs[i].e_s0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_valid", i), {63'd0, valid}, {63'd0, e[132]});
      check($sformatf("v%0d_op0", i), operand[63:0], e[67:4]);
      check($sformatf("v%0d_op1", i), operand[127:64], e[131:68]);
      if (e[133]) check($sformatf("v%0d_sel", i), {60'd0, fwd_sel}, {60'd0, e[3:0]});
    end

    // 6: reset mid-stall with valid=1 wins
    @(negedge clk);
    stall = 1; rst = 1;
    @(posedge clk);
    #1;
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_op", operand[63:0] | operand[127:64], 64'd0);
    check("midrst_sel", {60'd0, fwd_sel}, 64'd0);
    @(negedge clk); rst = 0; idle();

    // Sweep build, test 1: RF path on three ports
    rd_en3 = 3'b111; rd_addr3 = {5'd6, 5'd4, 5'd3}; rf3 = {32'h33, 32'h22, 32'h11};
    @(posedge clk); #1;
    check("p3_t1_op", {32'd0, operand3[31:0]} ^ {32'd0, operand3[63:32]}, 64'h33);
    check("p3_t1_op2", {32'd0, operand3[95:64]}, 64'h33);
    check("p3_t1_sel", {58'd0, fwd_sel3}, 64'd0);
    check("p3_t1_valid", {63'd0, valid3}, 64'd1);
    // test 2: EX priority, then MEM
    @(negedge clk);
    rd_addr3 = {5'd5, 5'd4, 5'd5};
    ex_we = 1; ex_a = 5; ex_d3 = 32'hA; mem_we = 1; mem_a = 5; mem_d3 = 32'hB;
    wb_we = 1; wb_a = 5; wb_d3 = 32'hC;
    @(posedge clk); #1;
    check("p3_t2_op0", {32'd0, operand3[31:0]}, 64'hA);
    check("p3_t2_sel", {58'd0, fwd_sel3}, {58'd0, 6'b01_00_01});
    @(negedge clk); ex_we = 0;
    @(posedge clk); #1;
    check("p3_t2b_op0", {32'd0, operand3[31:0]}, 64'hB);
    check("p3_t2b_op2", {32'd0, operand3[95:64]}, 64'hB);
    check("p3_t2b_sel", {58'd0, fwd_sel3}, {58'd0, 6'b10_00_10});
    // test 3: XZR
    @(negedge clk); idle();
    rd_en3 = 3'b001; rd_addr3 = 15'd31; rf3 = 96'h99; ex_we = 1; ex_a = 31; ex_d3 = 32'hFF;
    #1 check("p3_t3_lus", {63'd0, lus3}, 64'd0);
    @(posedge clk); #1;
    check("p3_t3_op0", {32'd0, operand3[31:0]}, 64'd0);
    // test 4: load-use on port2, then MEM forward
    @(negedge clk); idle();
    rd_en3 = 3'b100; rd_addr3 = {5'd7, 10'd0}; ex_we = 1; ex_ld = 1; ex_a = 7;
    #1 check("p3_t4_lus", {63'd0, lus3}, 64'd1);
    @(posedge clk); #1;
    check("p3_t4_valid", {63'd0, valid3}, 64'd0);
    @(negedge clk);
    ex_we = 0; ex_ld = 0; mem_we = 1; mem_a = 7; mem_d3 = 32'h55;
    @(posedge clk); #1;
    check("p3_t4_op2", {32'd0, operand3[95:64]}, 64'h55);
    check("p3_t4_sel", {62'd0, fwd_sel3[5:4]}, 64'd2);
    check("p3_t4_valid2", {63'd0, valid3}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
